// File: rtl/dff_ram_4x72_ctrl.sv
// Requester-side controller for the 4x72 DFF RAM: clears the array after reset,
// then serves one-per-cycle writes and single-outstanding reads over valid/ready.
module dff_ram_4x72_ctrl #(
    parameter int                 DEPTH      = 4,
    parameter int                 ADDR_W     = 2,
    parameter int                 DATA_W     = 72,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
        S_RSP
    } state_t;

    // One extra count past the last word gives a cycle to retire the final clear write.
    localparam logic [ADDR_W:0] CNT_END = (ADDR_W + 1)'(DEPTH);

    state_t              state_q;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                init_done_q;
    logic                ram_en_q;
    logic                ram_wr_q;
    logic [ADDR_W-1:0]   ram_address_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                req_fire;
    logic                rsp_fire;

    assign cnt_d    = cnt_q + 1'b1;
    assign req_fire = req_valid & req_ready_q;
    assign rsp_fire = rsp_valid_q & rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            init_done_q   <= 1'b0;
            ram_en_q      <= 1'b1;
            ram_wr_q      <= 1'b1;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    if (cnt_q == CNT_END) begin
                        ram_en_q    <= 1'b1;
                        ram_wr_q    <= 1'b1;
                        init_done_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        ram_en_q      <= 1'b0;
                        ram_wr_q      <= 1'b0;
                        ram_address_q <= cnt_q[ADDR_W-1:0];
                        ram_wdata_q   <= INIT_VALUE;
                        cnt_q         <= cnt_d;
                    end
                end
                S_IDLE: begin
                    if (req_fire && req_wr) begin
                        ram_en_q      <= 1'b0;
                        ram_wr_q      <= 1'b0;
                        ram_address_q <= req_addr;
                        ram_wdata_q   <= req_wdata;
                    end else if (req_fire) begin
                        ram_en_q      <= 1'b0;
                        ram_wr_q      <= 1'b1;
                        ram_address_q <= req_addr;
                        req_ready_q   <= 1'b0;
                        state_q       <= S_RD_ISSUE;
                    end else begin
                        ram_en_q <= 1'b1;
                        ram_wr_q <= 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    ram_en_q <= 1'b1;
                    ram_wr_q <= 1'b1;
                    state_q  <= S_RD_CAPTURE;
                end
                S_RD_CAPTURE: begin
                    // RAM registered the read at the previous edge.
                    rsp_rdata_q <= ram_rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign init_done   = init_done_q;
    assign ram_en      = ram_en_q;
    assign ram_wr      = ram_wr_q;
    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;

endmodule

// File: doc/dff_ram_4x72_ctrl.md
Name: dff_ram_4x72_ctrl

Overview:
Requester-side controller for the 4-word x 72-bit DFF RAM. It turns a valid/ready request stream (reads and writes) into the RAM's active-low enable and write-select pins, and returns read data on a valid/ready response channel. After reset it clears every RAM word to INIT_VALUE before accepting requests. It sits between the core's buffer logic and the dff_ram_4x72 macro.

Parameters:
DEPTH, 4, number of RAM words; must be a power of two.
ADDR_W, 2, address width, equal to log2(DEPTH).
DATA_W, 72, word width.
INIT_VALUE, 72'h0, value written to every word during the post-reset clear.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller accepts a request this cycle.
req_wr  in  1  1 selects write, 0 selects read.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  read data valid.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_W  read data.
init_done  out  1  post-reset clear complete.
ram_en  out  1  RAM enable, active-low.
ram_wr  out  1  RAM write select: 0 writes, 1 reads.
ram_address  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data, registered inside the RAM.

Behaviour:
- RAM contract:
  - Write: the RAM writes ram_wdata at the edge where ram_en=0 and ram_wr=0.
  - Read: the RAM samples the address at the edge where ram_en=0 and ram_wr=1. ram_rdata is valid after that edge.
- All ram_* outputs are registered.
- Reset values (while rst=1): state=INIT with counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, ram_en=1, ram_wr=1, ram_address=0, ram_wdata=0.
- FSM states: INIT, IDLE, RD_ISSUE, RD_CAPTURE, RSP.
- INIT:
  - One write per cycle: ram_en=0, ram_wr=0, ram_address=counter, ram_wdata=INIT_VALUE, for counter 0..DEPTH-1.
  - After the last write the state moves to IDLE, init_done goes to 1 and stays 1 until the next rst.
  - req_ready=0 throughout INIT.
- IDLE:
  - req_ready=1.
  - An accepted write (req_valid & req_ready & req_wr) drives ram_en=0, ram_wr=0 with the captured addr/data in the next cycle. The state stays IDLE, so back-to-back writes run at one per cycle.
  - An accepted read moves the state to RD_ISSUE. req_ready drops to 0 the cycle after accept.
  - With no accept, the next cycle has ram_en=1 and ram_wr=1.
- RD_ISSUE: ram_en=0, ram_wr=1, ram_address=captured addr for one cycle, then go to RD_CAPTURE.
- RD_CAPTURE: ram_en=1. rsp_rdata<=ram_rdata, rsp_valid<=1, then go to RSP.
- RSP:
  - rsp_rdata is held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid<=0 and state goes to IDLE. req_ready returns to 1 the following cycle.
- Read latency: accept at edge E0, rsp_valid rises after E2. Only one read is outstanding at a time.
- Read-after-write: a write accepted at E0 lands in the RAM at E1. A read accepted at E1 or later returns the new data.
- Write to the same address on consecutive cycles: the last write wins.
- req_addr wraps naturally at ADDR_W bits. No out-of-range case exists.
- rst in any state, including mid-read or while holding a response, aborts the operation:
  - Outputs return to reset values.
  - The pending response is discarded and the full clear re-runs.
- Inputs sampled while req_ready=0 are ignored. req_wdata/req_addr are don't-care when req_valid=0.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> exactly 4 cycles with ram_en=0, ram_wr=0 at addresses 0,1,2,3 and wdata=0; init_done=1 and req_ready=1 on the following cycle.
- Write then read: write addr 2 = 72'hCC0000000000000000, then read addr 2 -> rsp_valid 2 cycles after read accept with rsp_rdata=72'hCC0000000000000000.
- Back-to-back writes: addr0..3 = 72'h1,72'h2,72'h3,72'h4 on consecutive cycles with req_ready constantly 1, then read addr 3 then addr 0 -> 72'h4 then 72'h1.
- Response backpressure: read addr 1 (holding 72'hAAAAAAAAAAAAAAAAAA) with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; rsp_ready=1 -> single handshake, then req_ready=1 the next cycle.
- Reset mid-read: rst asserted in RD_CAPTURE -> rsp_valid never rises, the clear re-runs, and a subsequent read of addr 1 returns 72'h0.
- Clear overwrites data: write addr 0 = 72'hFF, pulse rst, wait for init_done, read addr 0 -> 72'h0.
